spi_slave_responder: RTL

- SPI mode-0 responder. It is the target-side counterpart of the team's SPI master, which drives a free-running clock and shifts MSB first with WIDTH-bit words.
- Oversamples the external sclk, cs_n and mosi in the CLK domain.
- Assembles each received WIDTH-bit word and pushes it out through a PipeIn-style response handshake.
- Shifts out a word taken from a PipeIn-style request handshake, MSB first.

---
 rtl/spi_slave_responder_if.sv | 33 +++
 rtl/spi_slave_responder.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/spi_slave_responder_if.sv
// Word handshake bundle between the SPI responder and its local producer/consumer.
// Latency: n/a (wires only).
// Backpressure: request side gated by request_enq__RDY, response side by response_enq__RDY.
interface spi_slave_responder_if #(
    parameter int WIDTH = 26
);
    logic             request_enq__ENA;
    logic [WIDTH-1:0] request_enq_v;
    logic             request_enq__RDY;
    logic             response_enq__ENA;
    logic [WIDTH-1:0] response_enq_v;
    logic             response_enq__RDY;

    // Responder side: accepts tx words, produces rx words.
    modport slave (
        input  request_enq__ENA,
        input  request_enq_v,
        output request_enq__RDY,
        output response_enq__ENA,
        output response_enq_v,
        input  response_enq__RDY
    );

    // Local user side: offers tx words, consumes rx words.
    modport master (
        output request_enq__ENA,
        output request_enq_v,
        input  request_enq__RDY,
        input  response_enq__ENA,
        input  response_enq_v,
        output response_enq__RDY
    );
endinterface

// File: rtl/spi_slave_responder.sv
// SPI mode-0 target: oversampled sclk/cs_n/mosi, MSB-first WIDTH-bit words in and out.
// Latency: SYNC_STAGES+1 CLK cycles from a pin edge to its effect; rx word visible 1 cycle after completion.
// Backpressure: one-deep tx/rx holding registers; empty tx gives underrun, full rx drops the word with overrun.
module spi_slave_responder #(
    parameter int WIDTH       = 26,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  sclk,
    input  logic                  cs_n,
    input  logic                  mosi,
    output logic                  miso,
    output logic                  overrun,
    output logic                  underrun,
    spi_slave_responder_if.slave  bus
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic {IDLE, ACTIVE} state_t;

    logic [SYNC_STAGES-1:0] sclk_q, cs_q, mosi_q;
    logic                   sclk_d, cs_d;
    // live[k] set once synchronizer stage k (k = SYNC_STAGES is the delay flop)
    // holds a genuine pin sample rather than its reset value.
    logic [SYNC_STAGES:0]   live;

    state_t           state;
    logic [WIDTH-1:0] txshift, rxshift, txbuf, rxbuf;
    logic [CW-1:0]    count;
    logic             reload, txvalid, rxvalid;

    logic             sclk_s, cs_s, mosi_s;
    logic             sclk_rise, sclk_fall, cs_fall, cs_rise, rx_take;
    logic [WIDTH-1:0] rx_next;

    assign sclk_s    = sclk_q[SYNC_STAGES-1];
    assign cs_s      = cs_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_d;
    assign sclk_fall = ~sclk_s & sclk_d;
    // A select that was already low when reset lifted must not look like a new frame.
    assign cs_fall   = live[SYNC_STAGES] & cs_d & ~cs_s;
    assign cs_rise   = cs_s & ~cs_d;
    assign rx_next   = {rxshift[WIDTH-2:0], mosi_s};

    assign bus.request_enq__RDY  = ~txvalid;
    assign bus.response_enq_v    = rxbuf;
    assign bus.response_enq__ENA = rxvalid & bus.response_enq__RDY;
    assign rx_take               = bus.response_enq__ENA;
    assign miso                  = (state == ACTIVE) ? txshift[WIDTH-1] : 1'b0;

    // Bring the asynchronous SPI pins into the CLK domain and keep one delay flop for edge detection.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sclk_q <= '0;
            cs_q   <= '1;
            mosi_q <= '0;
            sclk_d <= 1'b0;
            cs_d   <= 1'b1;
            live   <= '0;
        end else begin
            sclk_q <= {sclk_q[SYNC_STAGES-2:0], sclk};
            cs_q   <= {cs_q[SYNC_STAGES-2:0], cs_n};
            mosi_q <= {mosi_q[SYNC_STAGES-2:0], mosi};
            sclk_d <= sclk_s;
            cs_d   <= cs_s;
            live   <= {live[SYNC_STAGES-1:0], 1'b1};
        end
    end

    // Frame state machine with the tx/rx holding registers and the status pulses.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= IDLE;
            txshift  <= '0;
            rxshift  <= '0;
            txbuf    <= '0;
            rxbuf    <= '0;
            count    <= '0;
            reload   <= 1'b0;
            txvalid  <= 1'b0;
            rxvalid  <= 1'b0;
            overrun  <= 1'b0;
            underrun <= 1'b0;
        end else begin
            overrun  <= 1'b0;
            underrun <= 1'b0;

            // Only an empty holding register accepts; a same-cycle load can only hit a full one.
            if (bus.request_enq__ENA && !txvalid) begin
                txbuf   <= bus.request_enq_v;
                txvalid <= 1'b1;
            end
            if (rx_take) begin
                rxvalid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (cs_fall) begin
                        state  <= ACTIVE;
                        count  <= '0;
                        reload <= 1'b0;
                        if (txvalid) begin
                            txshift <= txbuf;
                            txvalid <= 1'b0;
                        end else begin
                            txshift  <= '0;
                            underrun <= 1'b1;
                        end
                    end
                end
                ACTIVE: begin
                    if (cs_rise) begin
                        // Deselect wins over any sclk edge; a partial word is silently dropped.
                        state   <= IDLE;
                        count   <= '0;
                        reload  <= 1'b0;
                        txshift <= '0;
                    end else if (sclk_rise) begin
                        rxshift <= rx_next;
                        if (count == CW'(WIDTH - 1)) begin
                            count  <= '0;
                            reload <= 1'b1;
                            if (!rxvalid || rx_take) begin
                                rxbuf   <= rx_next;
                                rxvalid <= 1'b1;
                            end else begin
                                overrun <= 1'b1;
                            end
                        end else begin
                            count <= count + CW'(1);
                        end
                    end else if (sclk_fall) begin
                        if (reload) begin
                            reload <= 1'b0;
                            if (txvalid) begin
                                txshift <= txbuf;
                                txvalid <= 1'b0;
                            end else begin
                                txshift  <= '0;
                                underrun <= 1'b1;
                            end
                        end else begin
                            txshift <= {txshift[WIDTH-2:0], 1'b0};
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
